// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and external memory bus signals
// around mem_port_arbiter. The master side is the arbiter itself; the
// slave side is the CPU core plus the external memory it is wired to.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int INST_WIDTH = 32
);
  // Instruction-fetch port
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_read;
  logic [INST_WIDTH-1:0] imem_read_data;
  logic                  imem_ready;

  // Data port
  logic [ADDR_WIDTH-1:0] dmem_addr;
  logic [DATA_WIDTH-1:0] dmem_write_data;
  logic                  dmem_read;
  logic                  dmem_write;
  logic [DATA_WIDTH-1:0] dmem_read_data;
  logic                  dmem_ready;

  // External memory port and status
  logic                  mem_req_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic                  mem_we_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic                  mem_ready_i;
  logic                  timeout_o;
  logic                  busy_o;

  modport master (
    input  imem_addr, imem_read,
    input  dmem_addr, dmem_write_data, dmem_read, dmem_write,
    input  mem_rdata_i, mem_ready_i,
    output imem_read_data, imem_ready,
    output dmem_read_data, dmem_ready,
    output mem_req_o, mem_addr_o, mem_wdata_o, mem_we_o,
    output timeout_o, busy_o
  );

  modport slave (
    output imem_addr, imem_read,
    output dmem_addr, dmem_write_data, dmem_read, dmem_write,
    output mem_rdata_i, mem_ready_i,
    input  imem_read_data, imem_ready,
    input  dmem_read_data, dmem_ready,
    input  mem_req_o, mem_addr_o, mem_wdata_o, mem_we_o,
    input  timeout_o, busy_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between the CPU fetch and data ports.
// Data accesses normally win a contest, but a saturating starve counter
// forces a fetch grant after STARVE_LIMIT consecutive lost contests.
// Each transaction runs IDLE -> GRANT -> RESP with a wait-cycle watchdog.
// All outputs are registered or decoded from registered state only.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int INST_WIDTH     = 32,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RESP} state_t;

  localparam logic [3:0]  STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [15:0] WAIT_LAST  = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [3:0]  starve_cnt;
  logic [15:0] wait_cnt;
  logic        imem_req;
  logic        dmem_req;
  logic        pick_i;

  // Selects the 32-bit instruction word out of the 64-bit bus beat.
  function automatic logic [INST_WIDTH-1:0] fetch_word(
    input logic                  hi,
    input logic [DATA_WIDTH-1:0] d
  );
    return hi ? d[DATA_WIDTH-1:INST_WIDTH] : d[INST_WIDTH-1:0];
  endfunction

  // Request decode and arbitration choice made while in IDLE.
  always_comb begin
    imem_req = bus.imem_read;
    dmem_req = bus.dmem_read | bus.dmem_write;
    pick_i   = imem_req && (!dmem_req || (starve_cnt == STARVE_MAX));
  end

  assign bus.busy_o = (state != IDLE);

  // Transaction sequencer: grant, latch, wait/watchdog, respond.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      starve_cnt         <= '0;
      wait_cnt           <= '0;
      bus.mem_req_o      <= 1'b0;
      bus.mem_addr_o     <= '0;
      bus.mem_wdata_o    <= '0;
      bus.mem_we_o       <= 1'b0;
      bus.imem_read_data <= '0;
      bus.imem_ready     <= 1'b0;
      bus.dmem_read_data <= '0;
      bus.dmem_ready     <= 1'b0;
      bus.timeout_o      <= 1'b0;
    end else begin
      bus.imem_ready <= 1'b0;
      bus.dmem_ready <= 1'b0;
      bus.timeout_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (imem_req || dmem_req) begin
            bus.mem_req_o <= 1'b1;
            wait_cnt      <= '0;
            if (pick_i) begin
              state           <= GRANT_I;
              bus.mem_addr_o  <= ADDR_WIDTH'(bus.imem_addr);
              bus.mem_wdata_o <= '0;
              bus.mem_we_o    <= 1'b0;
              starve_cnt      <= '0;
            end else begin
              state           <= GRANT_D;
              bus.mem_addr_o  <= bus.dmem_addr;
              bus.mem_wdata_o <= bus.dmem_write_data;
              // read+write together is treated as a store
              bus.mem_we_o    <= bus.dmem_write;
              if (imem_req && (starve_cnt != STARVE_MAX))
                starve_cnt <= starve_cnt + 4'd1;
            end
          end
        end
        GRANT_I, GRANT_D: begin
          // a ready arriving on the expiry cycle takes priority
          if (bus.mem_ready_i) begin
            bus.mem_req_o <= 1'b0;
            state         <= RESP;
            if (state == GRANT_I) begin
              bus.imem_ready     <= 1'b1;
              bus.imem_read_data <= fetch_word(bus.mem_addr_o[2], bus.mem_rdata_i);
            end else begin
              bus.dmem_ready <= 1'b1;
              if (!bus.mem_we_o) bus.dmem_read_data <= bus.mem_rdata_i;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            bus.mem_req_o <= 1'b0;
            bus.timeout_o <= 1'b1;
            state         <= RESP;
            if (state == GRANT_I) begin
              bus.imem_ready     <= 1'b1;
              bus.imem_read_data <= '0;
            end else begin
              bus.dmem_ready <= 1'b1;
              if (!bus.mem_we_o) bus.dmem_read_data <= '0;
            end
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, fetch with wait states,
// load, combined read/write store, fairness rotation, watchdog expiry,
// ready-at-expiry priority and reset during a data grant.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   nreq;
  int   ncyc;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .INST_WIDTH(32)) bus ();

  mem_port_arbiter #(
    .ADDR_WIDTH(64), .DATA_WIDTH(64), .INST_WIDTH(32),
    .STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.imem_addr       = '0;
    bus.imem_read       = 1'b0;
    bus.dmem_addr       = '0;
    bus.dmem_write_data = '0;
    bus.dmem_read       = 1'b0;
    bus.dmem_write      = 1'b0;
    bus.mem_rdata_i     = '0;
    bus.mem_ready_i     = 1'b0;

    // Reset, then one idle cycle
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_req",   bus.mem_req_o, 0);
    chk("rst_busy",  bus.busy_o, 0);
    chk("rst_iready", bus.imem_ready, 0);
    chk("rst_dready", bus.dmem_ready, 0);
    chk("rst_tmo",   bus.timeout_o, 0);
    chk("rst_addr",  bus.mem_addr_o, 0);
    chk("rst_we",    bus.mem_we_o, 0);
    chk("rst_wdata", bus.mem_wdata_o, 0);
    chk("rst_idata", bus.imem_read_data, 0);
    chk("rst_ddata", bus.dmem_read_data, 0);

    // Fetch at 0x1004 with three wait cycles
    bus.imem_addr = 64'h1004;
    bus.imem_read = 1'b1;
    step();
    chk("f_req",  bus.mem_req_o, 1);
    chk("f_addr", bus.mem_addr_o, 64'h1004);
    chk("f_we",   bus.mem_we_o, 0);
    chk("f_busy", bus.busy_o, 1);
    nreq = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.mem_req_o) nreq++;
      if (i == 3) begin
        bus.mem_ready_i = 1'b1;
        bus.mem_rdata_i = 64'hAAAA_BBBB_CCCC_DDDD;
      end
      step();
    end
    chk("f_req_cycles", nreq, 4);
    chk("f_req_drop",   bus.mem_req_o, 0);
    chk("f_iready",     bus.imem_ready, 1);
    chk("f_dready",     bus.dmem_ready, 0);
    chk("f_idata",      bus.imem_read_data, 64'hAAAA_BBBB);
    bus.imem_read   = 1'b0;
    bus.mem_ready_i = 1'b0;
    step();
    chk("f_iready_end", bus.imem_ready, 0);
    chk("f_idle",       bus.busy_o, 0);
    chk("f_idata_hold", bus.imem_read_data, 64'hAAAA_BBBB);

    // Load at 0x3000, ready on the first grant cycle
    bus.dmem_addr = 64'h3000;
    bus.dmem_read = 1'b1;
    step();
    chk("ld_addr", bus.mem_addr_o, 64'h3000);
    chk("ld_we",   bus.mem_we_o, 0);
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = 64'h1122_3344_5566_7788;
    step();
    chk("ld_dready", bus.dmem_ready, 1);
    chk("ld_ddata",  bus.dmem_read_data, 64'h1122_3344_5566_7788);
    bus.dmem_read   = 1'b0;
    bus.mem_ready_i = 1'b0;
    step();

    // Store with read and write both high
    bus.dmem_addr       = 64'h2000;
    bus.dmem_write_data = 64'h55;
    bus.dmem_read       = 1'b1;
    bus.dmem_write      = 1'b1;
    step();
    chk("st_we",    bus.mem_we_o, 1);
    chk("st_wdata", bus.mem_wdata_o, 64'h55);
    chk("st_addr",  bus.mem_addr_o, 64'h2000);
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = 64'hDEAD_BEEF_DEAD_BEEF;
    step();
    chk("st_dready", bus.dmem_ready, 1);
    chk("st_ddata_hold", bus.dmem_read_data, 64'h1122_3344_5566_7788);
    bus.dmem_read   = 1'b0;
    bus.dmem_write  = 1'b0;
    bus.mem_ready_i = 1'b0;
    step();

    // Fairness: both ports requesting, ready held high throughout
    bus.imem_addr   = 64'h100;
    bus.imem_read   = 1'b1;
    bus.dmem_addr   = 64'h200;
    bus.dmem_read   = 1'b1;
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = 64'h0123_4567_89AB_CDEF;
    for (int k = 0; k < 10; k++) begin
      step();
      chk($sformatf("fair_grant%0d", k), bus.mem_addr_o, ((k % 5) == 4) ? 64'h100 : 64'h200);
      step();
      chk($sformatf("fair_iready%0d", k), bus.imem_ready, ((k % 5) == 4) ? 1 : 0);
      chk($sformatf("fair_dready%0d", k), bus.dmem_ready, ((k % 5) == 4) ? 0 : 1);
      step();
    end
    bus.imem_read   = 1'b0;
    bus.dmem_read   = 1'b0;
    bus.mem_ready_i = 1'b0;
    chk("fair_ddata", bus.dmem_read_data, 64'h0123_4567_89AB_CDEF);

    // Watchdog expiry on a load with ready held low
    bus.dmem_addr = 64'h4000;
    bus.dmem_read = 1'b1;
    step();
    chk("to_req", bus.mem_req_o, 1);
    ncyc = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.timeout_o) break;
      step();
      ncyc++;
    end
    chk("to_cycles", ncyc, 8);
    chk("to_pulse",  bus.timeout_o, 1);
    chk("to_req_drop", bus.mem_req_o, 0);
    chk("to_dready", bus.dmem_ready, 1);
    chk("to_ddata",  bus.dmem_read_data, 0);
    bus.dmem_read = 1'b0;
    step();
    chk("to_pulse_end", bus.timeout_o, 0);

    // Next request after the abort proceeds normally (low half select)
    bus.imem_addr = 64'h8;
    bus.imem_read = 1'b1;
    step();
    chk("post_to_req", bus.mem_req_o, 1);
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = 64'hAAAA_BBBB_CCCC_DDDD;
    step();
    chk("post_to_iready", bus.imem_ready, 1);
    chk("post_to_idata",  bus.imem_read_data, 64'hCCCC_DDDD);
    chk("post_to_tmo",    bus.timeout_o, 0);
    bus.imem_read   = 1'b0;
    bus.mem_ready_i = 1'b0;
    step();

    // Ready arriving on the expiry cycle wins over the watchdog
    bus.dmem_addr = 64'h5000;
    bus.dmem_read = 1'b1;
    step();
    for (int i = 0; i < 7; i++) step();
    chk("edge_wait_req", bus.mem_req_o, 1);
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = 64'hFEDC_BA98_7654_3210;
    step();
    chk("edge_tmo",    bus.timeout_o, 0);
    chk("edge_dready", bus.dmem_ready, 1);
    chk("edge_ddata",  bus.dmem_read_data, 64'hFEDC_BA98_7654_3210);
    bus.dmem_read   = 1'b0;
    bus.mem_ready_i = 1'b0;
    step();

    // Reset while a data grant is outstanding
    bus.dmem_addr = 64'h6000;
    bus.dmem_read = 1'b1;
    step();
    chk("rg_busy", bus.busy_o, 1);
    rst = 1'b1;
    step();
    chk("rg_req",    bus.mem_req_o, 0);
    chk("rg_busy0",  bus.busy_o, 0);
    chk("rg_dready", bus.dmem_ready, 0);
    rst = 1'b0;
    bus.dmem_read = 1'b0;
    step();
    chk("rg_dready2", bus.dmem_ready, 0);
    chk("rg_tmo",     bus.timeout_o, 0);
    chk("rg_ddata",   bus.dmem_read_data, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
